spi_slave_ctrl: RTL

//  SPI slave frame controller, mode 0 (CPOL=0, CPHA=0), MSB first.
//  - Three sync_fd instances bring sclk_i, cs_n_i and mosi_i into the clk_i domain.
//  - The controller sequences RX/TX shifting from their synced levels and edge pulses.
//  - Presents received words and accepts transmit words on the system side.
//  - Sits between the SPI pads and the register/host logic of the SPI core.

---
 rtl/spi_slave_ctrl_if.sv | 24 ++
 rtl/spi_slave_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl_if.sv
// System-side word interface of the SPI slave controller: TX word handshake,
// RX word presentation and end-of-frame status.
interface spi_slave_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic              tx_underrun_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              frame_done_o;
    logic              partial_o;

    modport slave (
        input  tx_data_i, tx_valid_i,
        output tx_ready_o, tx_underrun_o, rx_data_o, rx_valid_o, frame_done_o, partial_o
    );

    modport master (
        output tx_data_i, tx_valid_i,
        input  tx_ready_o, tx_underrun_o, rx_data_o, rx_valid_o, frame_done_o, partial_o
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave frame controller, MSB first; pads are synchronised into clk_i (3-cycle pin latency).
// TX words are taken with a single-cycle ready pulse; RX has no backpressure (a new word overwrites).
module sync_fd (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] ff;

    // Resetting to 0 means a cs_n held low across reset never produces a falling pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) ff <= 3'b000;
        else       ff <= {ff[1:0], d_i};
    end

    assign q_o    = ff[1];
    assign rise_o = ff[1] & ~ff[2];
    assign fall_o = ~ff[1] & ff[2];
endmodule

module spi_slave_ctrl #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] DUMMY  = 'hFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    spi_slave_ctrl_if.slave   sys
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, RELOAD} state_t;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    sync_fd u_sync_sclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    sync_fd u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i), .q_o(cs_s),   .rise_o(cs_rise),   .fall_o(cs_fall));
    sync_fd u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

    logic unused_sync;
    assign unused_sync = sclk_s ^ cs_s ^ mosi_rise ^ mosi_fall;

    state_t            state, state_n;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_sh, tx_sh, rx_data;
    logic              rx_valid, frame_done, partial, oe;
    logic              load, tx_shift, rx_shift, word_done, end_frame;

    // cs_n rising takes priority over any sclk pulse in the same cycle.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        word_done = 1'b0;
        end_frame = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    end_frame = 1'b1;
                    state_n   = IDLE;
                end else if (sclk_rise) begin
                    rx_shift = 1'b1;
                    if (bit_cnt == LAST) begin
                        word_done = 1'b1;
                        state_n   = RELOAD;
                    end
                end else if (sclk_fall) begin
                    tx_shift = 1'b1;
                end
            end
            RELOAD: begin
                if (cs_rise) begin
                    end_frame = 1'b1;
                    state_n   = IDLE;
                end else if (sclk_fall) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            partial    <= 1'b0;
            oe         <= 1'b0;
        end else begin
            state      <= state_n;
            rx_valid   <= word_done;
            frame_done <= end_frame;
            partial    <= end_frame && (state == SHIFT) && (bit_cnt != '0);

            if (load)          tx_sh <= sys.tx_valid_i ? sys.tx_data_i : DUMMY;
            else if (tx_shift) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};

            if (load || end_frame) bit_cnt <= '0;
            else if (rx_shift)     bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);

            if (end_frame)     rx_sh <= '0;
            else if (rx_shift) rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};

            if (word_done) rx_data <= {rx_sh[DATA_W-2:0], mosi_s};

            if (load && state == IDLE) oe <= 1'b1;
            else if (end_frame)        oe <= 1'b0;
        end
    end

    assign sys.tx_ready_o    = load & sys.tx_valid_i & ~rst_i;
    assign sys.tx_underrun_o = load & ~sys.tx_valid_i & ~rst_i;
    assign sys.rx_data_o     = rx_data;
    assign sys.rx_valid_o    = rx_valid;
    assign sys.frame_done_o  = frame_done;
    assign sys.partial_o     = partial;
    assign miso_oe_o         = oe;
    assign miso_o            = oe & tx_sh[DATA_W-1];
endmodule
